// File: rtl/definitions.sv
// Opcode encodings shared by the control unit and its benches.
// Values 8..15 are unassigned and decode as generic ALU ops.
package definitions;

  localparam int OP_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] ADDi  = 4'h0;
  localparam logic [OP_WIDTH-1:0] STRm  = 4'h1;
  localparam logic [OP_WIDTH-1:0] LDR   = 4'h2;
  localparam logic [OP_WIDTH-1:0] Badd  = 4'h3;
  localparam logic [OP_WIDTH-1:0] Bsub  = 4'h4;
  localparam logic [OP_WIDTH-1:0] CMP   = 4'h5;
  localparam logic [OP_WIDTH-1:0] STOP  = 4'h6;
  localparam logic [OP_WIDTH-1:0] Label = 4'h7;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Control unit bundle: program/instruction inputs and datapath strobes.
// master = instruction source side, slave = ctrl_sequencer.
interface ctrl_sequencer_if #(
  parameter int INSTR_W = 9,
  parameter int PC_W    = 10
);
  logic               Start;
  logic [INSTR_W-1:0] Instruction;
  logic               BrCond;
  logic               PCEn;
  logic               BaddEn;
  logic               BsubEn;
  logic               Immediate_Reg;
  logic               RegWrEn;
  logic               MemWrEn;
  logic               LoadInst;
  logic               Stall;
  logic               Ack;
  logic [PC_W-1:0]    PCTarg;

  modport master (
    output Start, Instruction, BrCond,
    input  PCEn, BaddEn, BsubEn, Immediate_Reg,
    input  RegWrEn, MemWrEn, LoadInst, Stall,
    input  Ack, PCTarg
  );

  modport slave (
    input  Start, Instruction, BrCond,
    output PCEn, BaddEn, BsubEn, Immediate_Reg,
    output RegWrEn, MemWrEn, LoadInst, Stall,
    output Ack, PCTarg
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Opcode decoder plus sequencing FSM: Start/Ack handshake,
// multi-cycle load stalls and post-branch flush cycles.
module ctrl_sequencer
  import definitions::*;
#(
  parameter int INSTR_W     = 9,
  parameter int OP_W        = 4,
  parameter int PC_W        = 10,
  parameter int TARG_W      = 5,
  parameter bit TARG_SIGNED = 1'b0,
  parameter int LOAD_LAT    = 1,
  parameter int BR_FLUSH    = 1
) (
  input logic            Clk,
  input logic            Reset,
  ctrl_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RUN, LDWAIT, FLUSH, HALT
  } state_t;

  localparam bit LD_MULTI = (LOAD_LAT > 0);
  localparam bit BR_DEAD  = (BR_FLUSH > 0);

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic            ack;
  logic [OP_W-1:0] op;

  logic pcen, badd, bsub, imm;
  logic regwr, memwr, ldi, stall;

  assign op = bus.Instruction[INSTR_W-1 -: OP_W];

  // State, stall counter and registered Ack.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ack   <= (state_n == HALT);
    end
  end

  // Next state and strobes; strobes are zero unless the state enables them.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pcen    = 1'b0;
    badd    = 1'b0;
    bsub    = 1'b0;
    imm     = 1'b0;
    regwr   = 1'b0;
    memwr   = 1'b0;
    ldi     = 1'b0;
    stall   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.Start) state_n = RUN;
      end
      RUN: begin
        unique case (1'b1)
          (op == ADDi): begin
            imm   = 1'b1;
            regwr = 1'b1;
            pcen  = 1'b1;
          end
          (op == STRm): begin
            memwr = 1'b1;
            pcen  = 1'b1;
          end
          (op == LDR): begin
            if (LD_MULTI) begin
              cnt_n   = 4'(LOAD_LAT);
              state_n = LDWAIT;
            end else begin
              ldi   = 1'b1;
              regwr = 1'b1;
              pcen  = 1'b1;
            end
          end
          (op == Badd),
          (op == Bsub): begin
            pcen = 1'b1;
            if (bus.BrCond) begin
              badd = (op == Badd);
              bsub = (op == Bsub);
              if (BR_DEAD) begin
                cnt_n   = 4'(BR_FLUSH);
                state_n = FLUSH;
              end
            end
          end
          (op == CMP),
          (op == Label): begin
            pcen = 1'b1;
          end
          (op == STOP): begin
            state_n = HALT;
          end
          default: begin
            regwr = 1'b1;
            pcen  = 1'b1;
          end
        endcase
      end
      LDWAIT: begin
        stall = 1'b1;
        ldi   = 1'b1;
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          regwr   = 1'b1;
          pcen    = 1'b1;
          state_n = RUN;
        end
      end
      FLUSH: begin
        stall = 1'b1;
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) state_n = RUN;
      end
      HALT: begin
        if (bus.Start) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.PCEn          = pcen;
  assign bus.BaddEn        = badd;
  assign bus.BsubEn        = bsub;
  assign bus.Immediate_Reg = imm;
  assign bus.RegWrEn       = regwr;
  assign bus.MemWrEn       = memwr;
  assign bus.LoadInst      = ldi;
  assign bus.Stall         = stall;
  assign bus.Ack           = ack;

  generate
    if (TARG_W >= PC_W) begin : g_trunc
      assign bus.PCTarg = bus.Instruction[PC_W-1:0];
    end else begin : g_ext
      logic fill;
      assign fill = TARG_SIGNED & bus.Instruction[TARG_W-1];
      assign bus.PCTarg = {{(PC_W-TARG_W){fill}},
                           bus.Instruction[TARG_W-1:0]};
    end
  endgenerate

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer.
// Strobe vector s = {PCEn,BaddEn,BsubEn,Imm,RegWr,MemWr,LoadInst,Stall,Ack}.
module tb_ctrl_sequencer;
  import definitions::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ctrl_sequencer_if #(.INSTR_W(9), .PC_W(10)) bus ();
  ctrl_sequencer_if #(.INSTR_W(9), .PC_W(10)) bus2 ();

  ctrl_sequencer #(
    .LOAD_LAT(2), .BR_FLUSH(1), .TARG_SIGNED(1'b0)
  ) dut (
    .Clk(clk), .Reset(rst), .bus(bus)
  );

  ctrl_sequencer #(
    .LOAD_LAT(2), .BR_FLUSH(1), .TARG_SIGNED(1'b1)
  ) dut_s (
    .Clk(clk), .Reset(rst), .bus(bus2)
  );

  assign bus2.Start       = 1'b0;
  assign bus2.BrCond      = 1'b0;
  assign bus2.Instruction = bus.Instruction;

  logic [8:0] s;
  assign s = {bus.PCEn, bus.BaddEn, bus.BsubEn,
              bus.Immediate_Reg, bus.RegWrEn, bus.MemWrEn,
              bus.LoadInst, bus.Stall, bus.Ack};

  function automatic logic [8:0] ins(
    input logic [3:0] op, input logic [4:0] t);
    return {op, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_run();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic test_reset();
    bus.Start = 1'b0;
    bus.BrCond = 1'b0;
    bus.Instruction = ins(ADDi, 5'd0);
    @(negedge clk);
    total++;
    if (s !== 9'b0) begin
      bad++;
      $display("FAIL reset_hold got=%b want=%b", s, 9'b0);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (s !== 9'b0) begin
        bad++;
        $display("FAIL idle_wait%0d got=%b want=%b", i, s, 9'b0);
      end
      tick();
    end
    bus.Start = 1'b1;
    @(negedge clk);
    total++;
    if (s !== 9'b0) begin
      bad++;
      $display("FAIL idle_start got=%b want=%b", s, 9'b0);
    end
    tick();
    bus.Start = 1'b0;
    @(negedge clk);
    total++;
    if (s !== 9'b100110000) begin
      bad++;
      $display("FAIL run_after_start got=%b want=%b", s, 9'b100110000);
    end
    tick();
    rst = 1'b1;
    #1;
    total++;
    if (s !== 9'b0) begin
      bad++;
      $display("FAIL async_reset_run got=%b want=%b", s, 9'b0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (s !== 9'b0) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=%b", s, 9'b0);
    end
    tick();
  endtask

  task automatic test_decode();
    logic [3:0] ops [5];
    logic [8:0] exp [5];
    ops[0] = ADDi;  exp[0] = 9'b100110000;
    ops[1] = STRm;  exp[1] = 9'b100001000;
    ops[2] = CMP;   exp[2] = 9'b100000000;
    ops[3] = Label; exp[3] = 9'b100000000;
    ops[4] = 4'hF;  exp[4] = 9'b100010000;
    go_run();
    for (int i = 0; i < 5; i++) begin
      bus.Start = (i == 2);
      bus.Instruction = ins(ops[i], 5'd3);
      @(negedge clk);
      total++;
      if (s !== exp[i]) begin
        bad++;
        $display("FAIL decode_op%0h got=%b want=%b", ops[i], s, exp[i]);
      end
      tick();
    end
    bus.Start = 1'b0;
  endtask

  task automatic test_load();
    logic [8:0] exp [4];
    exp[0] = 9'b000000000;
    exp[1] = 9'b000000110;
    exp[2] = 9'b100010110;
    exp[3] = 9'b100110000;
    for (int i = 0; i < 4; i++) begin
      bus.Instruction = (i == 3) ? ins(ADDi, 5'd0) : ins(LDR, 5'd1);
      @(negedge clk);
      total++;
      if (s !== exp[i]) begin
        bad++;
        $display("FAIL load_cyc%0d got=%b want=%b", i + 1, s, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    bus.Instruction = ins(Badd, 5'b10110);
    bus.BrCond = 1'b1;
    @(negedge clk);
    total++;
    if (s !== 9'b110000000) begin
      bad++;
      $display("FAIL badd_taken got=%b want=%b", s, 9'b110000000);
    end
    total++;
    if (bus.PCTarg !== 10'h016) begin
      bad++;
      $display("FAIL targ_zext got=%h want=%h", bus.PCTarg, 10'h016);
    end
    total++;
    if (bus2.PCTarg !== 10'h3F6) begin
      bad++;
      $display("FAIL targ_sext got=%h want=%h", bus2.PCTarg, 10'h3F6);
    end
    tick();
    bus.Instruction = ins(ADDi, 5'd0);
    @(negedge clk);
    total++;
    if (s !== 9'b000000010) begin
      bad++;
      $display("FAIL badd_flush got=%b want=%b", s, 9'b000000010);
    end
    tick();
    bus.BrCond = 1'b0;
    @(negedge clk);
    total++;
    if (s !== 9'b100110000) begin
      bad++;
      $display("FAIL after_flush got=%b want=%b", s, 9'b100110000);
    end
    tick();
    bus.Instruction = ins(Badd, 5'b00101);
    @(negedge clk);
    total++;
    if (s !== 9'b100000000) begin
      bad++;
      $display("FAIL badd_not_taken got=%b want=%b", s, 9'b100000000);
    end
    total++;
    if (bus2.PCTarg !== 10'h005) begin
      bad++;
      $display("FAIL targ_pos got=%h want=%h", bus2.PCTarg, 10'h005);
    end
    tick();
    bus.Instruction = ins(ADDi, 5'd0);
    @(negedge clk);
    total++;
    if (s !== 9'b100110000) begin
      bad++;
      $display("FAIL no_flush got=%b want=%b", s, 9'b100110000);
    end
    tick();
    bus.Instruction = ins(Bsub, 5'd2);
    bus.BrCond = 1'b1;
    @(negedge clk);
    total++;
    if (s !== 9'b101000000) begin
      bad++;
      $display("FAIL bsub_taken got=%b want=%b", s, 9'b101000000);
    end
    tick();
    bus.BrCond = 1'b0;
    @(negedge clk);
    total++;
    if (s !== 9'b000000010) begin
      bad++;
      $display("FAIL bsub_flush got=%b want=%b", s, 9'b000000010);
    end
    tick();
  endtask

  task automatic test_stop();
    bus.Instruction = ins(STOP, 5'd0);
    @(negedge clk);
    total++;
    if (s !== 9'b0) begin
      bad++;
      $display("FAIL stop_cycle got=%b want=%b", s, 9'b0);
    end
    tick();
    bus.Instruction = ins(ADDi, 5'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (s !== 9'b000000001) begin
        bad++;
        $display("FAIL halt_ack%0d got=%b want=%b", i, s, 9'b000000001);
      end
      tick();
    end
    bus.Start = 1'b1;
    @(negedge clk);
    total++;
    if (s !== 9'b000000001) begin
      bad++;
      $display("FAIL halt_start got=%b want=%b", s, 9'b000000001);
    end
    tick();
    bus.Start = 1'b0;
    @(negedge clk);
    total++;
    if (s !== 9'b100110000) begin
      bad++;
      $display("FAIL resume got=%b want=%b", s, 9'b100110000);
    end
    tick();
  endtask

  task automatic test_reset_ldwait();
    bus.Instruction = ins(LDR, 5'd0);
    tick();
    @(negedge clk);
    total++;
    if (s !== 9'b000000110) begin
      bad++;
      $display("FAIL ldwait_entry got=%b want=%b", s, 9'b000000110);
    end
    rst = 1'b1;
    #1;
    total++;
    if (s !== 9'b0) begin
      bad++;
      $display("FAIL ldwait_async got=%b want=%b", s, 9'b0);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (s !== 9'b0) begin
        bad++;
        $display("FAIL ldwait_no_write%0d got=%b want=%b", i, s, 9'b0);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load();
    test_branch();
    test_stop();
    test_reset_ldwait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
